// File: rtl/calc_cmd_ctrl_if.sv
// calc_cmd_ctrl_if -- bundle of the command-controller side signals.
//   rx_data/rx_valid      : received ASCII byte stream
//   op_a/op_b/op_sel/signed_mode/alu_start/alu_done/alu_result : ALU launch and completion
//   tx_data/tx_start/tx_busy : byte transmitter handshake
//   rx_drop               : pulse when a received byte is discarded
// slave  = controller side, master = environment (UART/ALU) side.
interface calc_cmd_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [1:0]  op_sel;
  logic        signed_mode;
  logic        alu_start;
  logic        alu_done;
  logic [31:0] alu_result;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        rx_drop;

  modport slave (
    input  rx_data, rx_valid, alu_done, alu_result, tx_busy,
    output op_a, op_b, op_sel, signed_mode, alu_start, tx_data, tx_start, rx_drop
  );
  modport master (
    output rx_data, rx_valid, alu_done, alu_result, tx_busy,
    input  op_a, op_b, op_sel, signed_mode, alu_start, tx_data, tx_start, rx_drop
  );
endinterface

// File: rtl/calc_cmd_ctrl.sv
// calc_cmd_ctrl -- parses "I <U|S> <A><op><B>=" ASCII command frames, launches
// the ALU, and returns the 32-bit result as 8 hex characters plus CR. Any parse
// error, divide-by-zero or ALU timeout answers "?" plus CR.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : calc_cmd_ctrl_if.slave (rx stream, ALU handshake, tx handshake)
// Parameters: DIGITS (1-4) digits per operand, TIMEOUT cycles to wait for alu_done.
module calc_cmd_ctrl #(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  calc_cmd_ctrl_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, SP1, MODE, SP2, DIG_A, OPER, DIG_B, EQ,
    EXEC, WAIT_ALU, TX_LOAD, TX_WAIT, ERR
  } state_t;

  state_t      r_state;
  logic [15:0] r_acc;
  logic [2:0]  r_dcnt;
  logic [15:0] r_op_a, r_op_b;
  logic [1:0]  r_op_sel;
  logic        r_signed;
  logic        r_alu_start;
  logic [31:0] r_result;
  logic [TW-1:0] r_tmo;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;
  logic [3:0]  r_tx_idx;
  logic        r_tx_err;   // 1: sending the "?",CR error reply
  logic        r_skip;     // tx_busy is not yet valid the cycle after tx_start
  logic        r_rx_drop;

  logic [7:0]  w_byte;
  logic        w_is_dig;
  logic [15:0] w_acc_next;
  logic        w_dig_last;
  logic [4:0]  w_sh;
  logic [3:0]  w_nib;
  logic [7:0]  w_hex;
  logic [7:0]  w_tx_char;
  logic        w_tx_last;
  logic        w_busy_st;

  assign w_byte     = bus.rx_data;
  assign w_is_dig   = (w_byte >= 8'h30) && (w_byte <= 8'h39);
  // 999*10+9 = 9999 is the largest possible value, fits in 16 bits
  assign w_acc_next = r_acc * 16'd10 + {12'd0, w_byte[3:0]};
  assign w_dig_last = (r_dcnt == 3'(DIGITS - 1));

  // Result characters go out most significant nibble first
  assign w_sh      = 5'd28 - {r_tx_idx[2:0], 2'b00};
  assign w_nib     = r_result[w_sh +: 4];
  assign w_hex     = (w_nib < 4'd10) ? (8'h30 + {4'd0, w_nib}) : (8'h37 + {4'd0, w_nib});
  assign w_tx_char = r_tx_err ? ((r_tx_idx == 4'd0) ? 8'h3F : 8'h0D)
                              : ((r_tx_idx == 4'd8) ? 8'h0D : w_hex);
  assign w_tx_last = r_tx_err ? (r_tx_idx == 4'd1) : (r_tx_idx == 4'd8);

  assign w_busy_st = (r_state == EXEC) || (r_state == WAIT_ALU) || (r_state == TX_LOAD) ||
                     (r_state == TX_WAIT) || (r_state == ERR);

  assign bus.op_a        = r_op_a;
  assign bus.op_b        = r_op_b;
  assign bus.op_sel      = r_op_sel;
  assign bus.signed_mode = r_signed;
  assign bus.alu_start   = r_alu_start;
  assign bus.tx_data     = r_tx_data;
  assign bus.tx_start    = r_tx_start;
  assign bus.rx_drop     = r_rx_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_dcnt      <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_sel    <= '0;
      r_signed    <= 1'b0;
      r_alu_start <= 1'b0;
      r_result    <= '0;
      r_tmo       <= '0;
      r_tx_data   <= '0;
      r_tx_start  <= 1'b0;
      r_tx_idx    <= '0;
      r_tx_err    <= 1'b0;
      r_skip      <= 1'b0;
      r_rx_drop   <= 1'b0;
    end else begin
      r_alu_start <= 1'b0;
      r_tx_start  <= 1'b0;
      r_rx_drop   <= bus.rx_valid && w_busy_st;
      case (r_state)
        IDLE: if (bus.rx_valid && w_byte == 8'h49) r_state <= SP1;
        SP1:  if (bus.rx_valid) r_state <= (w_byte == 8'h20) ? MODE : ERR;
        MODE: if (bus.rx_valid) begin
          if (w_byte == 8'h55) begin
            r_signed <= 1'b0;
            r_state  <= SP2;
          end else if (w_byte == 8'h53) begin
            r_signed <= 1'b1;
            r_state  <= SP2;
          end else r_state <= ERR;
        end
        SP2: if (bus.rx_valid) begin
          r_acc   <= '0;
          r_dcnt  <= '0;
          r_state <= (w_byte == 8'h20) ? DIG_A : ERR;
        end
        DIG_A, DIG_B: if (bus.rx_valid) begin
          if (!w_is_dig) r_state <= ERR;
          else if (w_dig_last) begin
            if (r_state == DIG_A) begin
              r_op_a  <= w_acc_next;
              r_state <= OPER;
            end else begin
              r_op_b  <= w_acc_next;
              r_state <= EQ;
            end
            r_acc  <= '0;
            r_dcnt <= '0;
          end else begin
            r_acc  <= w_acc_next;
            r_dcnt <= r_dcnt + 3'd1;
          end
        end
        OPER: if (bus.rx_valid) begin
          r_state <= DIG_B;
          case (w_byte)
            8'h2B:   r_op_sel <= 2'b00;
            8'h2D:   r_op_sel <= 2'b01;
            8'h2A:   r_op_sel <= 2'b10;
            8'h2F:   r_op_sel <= 2'b11;
            default: r_state  <= ERR;
          endcase
        end
        EQ: if (bus.rx_valid) begin
          if (w_byte != 8'h3D) r_state <= ERR;
          else if (r_op_sel == 2'b11 && r_op_b == 16'd0) r_state <= ERR;
          else begin
            r_alu_start <= 1'b1;   // high for the single EXEC cycle
            r_state     <= EXEC;
          end
        end
        EXEC: begin
          r_tmo   <= '0;
          r_state <= WAIT_ALU;
        end
        WAIT_ALU: begin
          if (bus.alu_done) begin
            r_result <= bus.alu_result;
            r_tx_err <= 1'b0;
            r_tx_idx <= '0;
            r_state  <= TX_LOAD;
          end else if (r_tmo == TW'(TIMEOUT - 1)) r_state <= ERR;
          else r_tmo <= r_tmo + TW'(1);
        end
        TX_LOAD: if (!bus.tx_busy) begin
          r_tx_data  <= w_tx_char;
          r_tx_start <= 1'b1;
          r_skip     <= 1'b1;
          r_state    <= TX_WAIT;
        end
        TX_WAIT: begin
          if (r_skip) r_skip <= 1'b0;
          else if (!bus.tx_busy) begin
            if (w_tx_last) r_state <= IDLE;
            else begin
              r_tx_idx <= r_tx_idx + 4'd1;
              r_state  <= TX_LOAD;
            end
          end
        end
        ERR: begin
          r_tx_err <= 1'b1;
          r_tx_idx <= '0;
          r_state  <= TX_LOAD;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/calc_cmd_ctrl.md
CALC_CMD_CTRL -- requirements
Module: calc_cmd_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, decimal digits per operand (1-4).
REQ-002 Parameter TIMEOUT, default 255, max cycles waiting for alu_done.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_data  input  8  received ASCII byte, valid with rx_valid.
REQ-006 rx_valid  input  1  one-cycle strobe per received byte.
REQ-007 op_a  output  16  operand A, binary.
REQ-008 op_b  output  16  operand B, binary.
REQ-009 op_sel  output  2  00 add, 01 sub, 10 mul, 11 div.
REQ-010 signed_mode  output  1  1 for 'S', 0 for 'U'.
REQ-011 alu_start  output  1  one-cycle launch strobe to the ALU.
REQ-012 alu_done  input  1  one-cycle ALU completion strobe.
REQ-013 alu_result  input  32  ALU result, valid with alu_done.
REQ-014 tx_data  output  8  byte to transmit.
REQ-015 tx_start  output  1  one-cycle transmit request.
REQ-016 tx_busy  input  1  transmitter busy; goes high the cycle after tx_start.
REQ-017 rx_drop  output  1  one-cycle pulse when a received byte is discarded.

Function
REQ-018 The frame SHALL be 'I', 0x20, 'U'|'S', 0x20, DIGITS digits, operator ('+' 0x2B, '-' 0x2D, '*' 0x2A, '/' 0x2F), DIGITS digits, '=' 0x3D.
REQ-019 States SHALL be IDLE, SP1, MODE, SP2, DIG_A, OPER, DIG_B, EQ, EXEC, WAIT_ALU, TX_LOAD, TX_WAIT, ERR.
REQ-020 IDLE SHALL ignore every byte except 'I', which moves to SP1 without error.
REQ-021 In SP1..EQ, each rx_valid byte SHALL advance one field if it matches and SHALL move to ERR otherwise.
REQ-022 Each digit SHALL update acc <= acc*10 + (byte-0x30); a digit counter SHALL move to the next field after exactly DIGITS digits.
REQ-023 The operand accumulator SHALL be 16 bits; the maximum value 9999 SHALL never overflow.
REQ-024 op_a, op_b, op_sel and signed_mode SHALL stay stable from the accepted '=' until return to IDLE.
REQ-025 On '=', an op_sel=11 frame with op_b=0 SHALL go to ERR without asserting alu_start.
REQ-026 Otherwise EXEC SHALL assert alu_start for exactly one cycle, the cycle after '=' is accepted, then enter WAIT_ALU.
REQ-027 WAIT_ALU SHALL capture alu_result into a 32-bit register on alu_done.
REQ-028 If alu_done is absent for TIMEOUT cycles after alu_start, WAIT_ALU SHALL go to ERR.
REQ-029 The response SHALL be 8 uppercase hex ASCII characters, most significant nibble first, followed by 0x0D.
REQ-030 TX_LOAD SHALL pulse tx_start only when tx_busy=0; TX_WAIT SHALL skip one cycle, then wait for tx_busy=0.
REQ-031 After the 0x0D completes, the block SHALL return to IDLE.
REQ-032 ERR SHALL transmit '?' (0x3F) then 0x0D using the same handshake, then return to IDLE.
REQ-033 A byte arriving in EXEC, WAIT_ALU, TX_LOAD, TX_WAIT or ERR SHALL be discarded with a one-cycle rx_drop pulse.
REQ-034 alu_done outside WAIT_ALU SHALL be ignored.
REQ-035 alu_start and tx_start SHALL never both be high in the same cycle.

Reset
REQ-036 While rst is high, the state SHALL be IDLE and op_a, op_b, op_sel, signed_mode, tx_data and the result register SHALL be 0.
REQ-037 While rst is high, alu_start, tx_start and rx_drop SHALL be 0, and the counters SHALL be cleared.
REQ-038 Reset asserted mid-frame, mid-ALU or mid-TX SHALL abort immediately with no further strobes; the next frame after release SHALL be parsed normally.

Verification
REQ-039 Frame "I U 0004+0008=" -> alu_start with op_a=4, op_b=8, op_sel=00, signed_mode=0; alu_result=12 -> TX "0000000C",0x0D.
REQ-040 Frame "I S 0004-0002=" -> op_sel=01, signed_mode=1; result 2 -> TX "00000002",0x0D.
REQ-041 Frame "I S 0003*0007=" -> op_sel=10; result 21 -> TX "00000015",0x0D.
REQ-042 Frame "I U 0005/0000=" -> no alu_start, TX '?',0x0D; "I X" -> '?',0x0D; the next valid frame is processed correctly.
REQ-043 No alu_done for 255 cycles -> TX '?',0x0D; a byte sent during TX -> rx_drop pulse and the frame is unaffected.
REQ-044 rst during the 4th TX character -> tx_start stays low and the state is IDLE; a following "I U 0001+0001=" -> TX "00000002",0x0D.
